// File: rtl/lane_mix_engine.sv
// Iterative lane mixing engine: seeds LANES words, applies one full add-chain or
// xor-shift round per clock, then pulses done with an XOR checksum of the lanes.
module lane_mix_engine #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 8,
    parameter int unsigned RND_W = 8,
    parameter int unsigned SHIFT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [RND_W-1:0]         rounds,
    input  logic [WIDTH-1:0]         seed,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         checksum,
    input  logic [$clog2(LANES)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    localparam int unsigned IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   lanes     [LANES];
    logic [WIDTH-1:0]   lanes_nxt [LANES];
    logic [WIDTH-1:0]   mix       [LANES];
    logic [RND_W-1:0]   cnt, cnt_nxt;
    logic [RND_W-1:0]   rounds_q, rounds_nxt;
    logic               mode_q, mode_nxt;
    logic               busy_nxt, done_nxt;
    logic [WIDTH-1:0]   checksum_nxt, fold;

    // One full round as an in-place chain; later lanes see earlier updates.
    always_comb begin
        for (int i = 0; i < LANES; i++) mix[IDX_W'(i)] = lanes[IDX_W'(i)];
        for (int i = 0; i < LANES; i++) begin
            if (mode_q) begin
                mix[IDX_W'(i)] = mix[IDX_W'(i)] ^ (mix[IDX_W'((i + 3) % LANES)] << SHIFT);
            end else begin
                mix[IDX_W'(i)] = mix[IDX_W'(i)] + mix[IDX_W'((i + LANES - 1) % LANES)]
                               - mix[IDX_W'((i + LANES - 2) % LANES)];
            end
        end
    end

    always_comb begin
        fold = '0;
        for (int i = 0; i < LANES; i++) fold = fold ^ lanes_nxt[IDX_W'(i)];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rounds_nxt   = rounds_q;
        mode_nxt     = mode_q;
        checksum_nxt = checksum;
        for (int i = 0; i < LANES; i++) lanes_nxt[IDX_W'(i)] = lanes[IDX_W'(i)];

        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt   = mode;
                    rounds_nxt = rounds;
                    for (int i = 0; i < LANES; i++) lanes_nxt[IDX_W'(i)] = seed + WIDTH'(i);
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                if (rounds_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt   = rounds_q;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    for (int i = 0; i < LANES; i++) lanes_nxt[IDX_W'(i)] = mix[IDX_W'(i)];
                    cnt_nxt = cnt - RND_W'(1);
                    if (cnt == RND_W'(1)) state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == LOAD) || (state_nxt == RUN);
        done_nxt = (state_nxt == DONE);
        if (done_nxt) checksum_nxt = fold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rounds_q <= '0;
            mode_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            checksum <= '0;
            rd_data  <= '0;
            for (int i = 0; i < LANES; i++) lanes[IDX_W'(i)] <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rounds_q <= rounds_nxt;
            mode_q   <= mode_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            checksum <= checksum_nxt;
            for (int i = 0; i < LANES; i++) lanes[IDX_W'(i)] <= lanes_nxt[IDX_W'(i)];
            // Read port samples the pre-edge lane values; out-of-range selects read 0.
            if (32'(rd_idx) < LANES) rd_data <= lanes[rd_idx];
            else                     rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_lane_mix_engine.sv
// Self-checking bench for lane_mix_engine: fixed vectors plus randomized runs
// checked against a behavioural lane model.
module tb_lane_mix_engine;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 8;
    localparam int unsigned RND_W = 8;
    localparam int unsigned SHIFT = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             mode;
    logic [RND_W-1:0] rounds;
    logic [WIDTH-1:0] seed;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;
    logic [2:0]       rd_idx;
    logic [WIDTH-1:0] rd_data;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] ref_s   [LANES];
    logic [WIDTH-1:0] rd_seen [LANES];

    lane_mix_engine #(.WIDTH(WIDTH), .LANES(LANES), .RND_W(RND_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .rounds(rounds),
        .seed(seed), .abort(abort), .busy(busy), .done(done), .checksum(checksum),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic void model_load(input logic [WIDTH-1:0] s);
        for (int i = 0; i < LANES; i++) ref_s[i] = s + i;
    endfunction

    function automatic void model_round(input logic m);
        for (int i = 0; i < LANES; i++) begin
            int prev1 = (i + LANES - 1) % LANES;
            int prev2 = (i + LANES - 2) % LANES;
            int ahead = (i + 3) % LANES;
            if (m) ref_s[i] = ref_s[i] ^ (ref_s[ahead] << SHIFT);
            else   ref_s[i] = ref_s[i] + ref_s[prev1] - ref_s[prev2];
        end
    endfunction

    function automatic logic [WIDTH-1:0] model_xor();
        logic [WIDTH-1:0] x = '0;
        for (int i = 0; i < LANES; i++) x ^= ref_s[i];
        return x;
    endfunction

    task automatic read_all();
        for (int i = 0; i < LANES; i++) begin
            rd_idx = 3'(i);
            @(posedge clk); #1;
            rd_seen[i] = rd_data;
        end
    endtask

    // Issues one start and watches a bounded window for busy/done activity.
    task automatic launch(input logic [WIDTH-1:0] s, input logic m, input int n,
                          output int dcyc, output int pulses, output int bcnt);
        dcyc = -1; pulses = 0; bcnt = 0;
        seed = s; mode = m; rounds = RND_W'(n); start = 1'b1;
        for (int c = 1; c <= n + 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                pulses++;
                if (dcyc < 0) dcyc = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; rounds = '0; seed = '0; abort = 1'b0; rd_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        read_all();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_seen[i] !== '0) begin errors++; $display("FAIL reset_lane%0d: got %h expected 0", i, rd_seen[i]); end
        end
    endtask

    task automatic check_add_vector(input string tag);
        logic [WIDTH-1:0] exp_l [LANES] = '{32'h1, 32'hFFFFFFFB, 32'hFFFFFFFC, 32'h4,
                                            32'hC, 32'hD, 32'h7, 32'h1};
        int dcyc, pulses, bcnt;
        launch(32'h0, 1'b0, 1, dcyc, pulses, bcnt);
        checks++; if (dcyc != 3) begin errors++; $display("FAIL %s_latency: got %0d expected 3", tag, dcyc); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL %s_pulses: got %0d expected 1", tag, pulses); end
        checks++; if (checksum !== 32'h5) begin errors++; $display("FAIL %s_checksum: got %h expected 5", tag, checksum); end
        read_all();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_seen[i] !== exp_l[i]) begin errors++; $display("FAIL %s_lane%0d: got %h expected %h", tag, i, rd_seen[i], exp_l[i]); end
        end
    endtask

    task automatic test_add_round();
        check_add_vector("add");
    endtask

    task automatic test_xor_round();
        logic [WIDTH-1:0] exp_l [LANES] = '{32'h30000, 32'h40001, 32'h50002, 32'h60003,
                                            32'h70004, 32'h5, 32'h10006, 32'h20007};
        int dcyc, pulses, bcnt;
        launch(32'h0, 1'b1, 1, dcyc, pulses, bcnt);
        checks++; if (dcyc != 3) begin errors++; $display("FAIL xor_latency: got %0d expected 3", dcyc); end
        checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL xor_checksum: got %h expected 0", checksum); end
        read_all();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_seen[i] !== exp_l[i]) begin errors++; $display("FAIL xor_lane%0d: got %h expected %h", i, rd_seen[i], exp_l[i]); end
        end
    endtask

    task automatic test_zero_rounds();
        int dcyc, pulses, bcnt;
        launch(32'h10, 1'b0, 0, dcyc, pulses, bcnt);
        checks++; if (dcyc != 2) begin errors++; $display("FAIL zero_latency: got %0d expected 2", dcyc); end
        checks++; if (bcnt != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 1", bcnt); end
        checks++; if (checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum: got %h expected 0", checksum); end
        read_all();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_seen[i] !== 32'(32'h10 + i)) begin errors++; $display("FAIL zero_lane%0d: got %h expected %h", i, rd_seen[i], 32'(32'h10 + i)); end
        end
    endtask

    task automatic test_abort();
        for (int rep = 0; rep < 2; rep++) begin
            logic [WIDTH-1:0] s = $urandom;
            logic m = rep[0];
            logic [WIDTH-1:0] prev_ck = checksum;
            int done_seen = 0;
            int mism = 0;
            seed = s; mode = m; rounds = RND_W'(100); start = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                if (done) done_seen++;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_run c%0d: got %b expected 1", c, busy); end
                if (c == 6) begin start = 1'b0; abort = 1'b1; end
            end
            @(posedge clk); #1;
            abort = 1'b0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_drop: got %b expected 0", busy); end
            repeat (4) begin
                @(posedge clk); #1;
                if (done) done_seen++;
            end
            checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
            checks++; if (checksum !== prev_ck) begin errors++; $display("FAIL abort_checksum_hold: got %h expected %h", checksum, prev_ck); end
            model_load(s);
            repeat (4) model_round(m);
            read_all();
            for (int i = 0; i < LANES; i++) if (rd_seen[i] !== ref_s[i]) mism++;
            checks++; if (mism != 0) begin errors++; $display("FAIL abort_lanes mode%0d: got %0d lane differences expected 0", m, mism); end
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            logic [WIDTH-1:0] s = $urandom;
            logic m = 1'($urandom_range(0, 1));
            int n = $urandom_range(1, 12);
            int dcyc, pulses, bcnt;
            int mism = 0;
            launch(s, m, n, dcyc, pulses, bcnt);
            model_load(s);
            repeat (n) model_round(m);
            checks++; if (dcyc != n + 2) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, dcyc, n + 2); end
            checks++; if (bcnt != n + 1) begin errors++; $display("FAIL rand%0d_busy_cycles: got %0d expected %0d", r, bcnt, n + 1); end
            checks++; if (checksum !== model_xor()) begin errors++; $display("FAIL rand%0d_checksum: got %h expected %h", r, checksum, model_xor()); end
            read_all();
            for (int i = 0; i < LANES; i++) if (rd_seen[i] !== ref_s[i]) mism++;
            checks++; if (mism != 0) begin errors++; $display("FAIL rand%0d_lanes: got %0d lane differences expected 0", r, mism); end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] s = $urandom;
        int first = -1, second = -1, pulses = 0, mism = 0;
        seed = s; mode = 1'b1; rounds = RND_W'(2); start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 6) start = 1'b0;
            if (done) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        checks++; if (first != 4) begin errors++; $display("FAIL b2b_first_done: got %0d expected 4", first); end
        checks++; if (second != 9) begin errors++; $display("FAIL b2b_second_done: got %0d expected 9", second); end
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
        model_load(s);
        repeat (2) model_round(1'b1);
        read_all();
        for (int i = 0; i < LANES; i++) if (rd_seen[i] !== ref_s[i]) mism++;
        checks++; if (mism != 0) begin errors++; $display("FAIL b2b_lanes: got %0d lane differences expected 0", mism); end
    endtask

    task automatic test_reset_mid_run();
        seed = $urandom; mode = 1'b0; rounds = RND_W'(50); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL midrst_rd_data: got %h expected 0", rd_data); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (checksum !== '0) begin errors++; $display("FAIL midrst_checksum: got %h expected 0", checksum); end
        read_all();
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_seen[i] !== '0) begin errors++; $display("FAIL midrst_lane%0d: got %h expected 0", i, rd_seen[i]); end
        end
        check_add_vector("rerun");
    endtask

    initial begin
        test_reset();
        test_add_round();
        test_xor_round();
        test_zero_rounds();
        test_abort();
        test_random_runs();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lane_mix_engine.md
Name: lane_mix_engine

Overview:
- Parametrised iterative mixing engine holding LANES state words of WIDTH bits.
- After a start handshake it seeds the lanes, then applies one full round per clock for a run-time round count, selecting an add-chain or xor-shift round.
- On completion it pulses done and presents an XOR checksum; any lane can be read at any time.
- Used as a heavy-arithmetic workload generator and a simulator stress block.

Parameters:
- WIDTH, 32, bits per lane word; all arithmetic is modulo 2^WIDTH.
- LANES, 8, number of state lanes; legal range 4..16.
- RND_W, 8, width of the round-count input.
- SHIFT, 16, left-shift distance used by mode 1; must be less than WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to run; sampled only in IDLE.
- mode  in  1  0 = add-chain round, 1 = xor-shift round; latched at accepted start.
- rounds  in  RND_W  number of rounds to apply; latched at accepted start.
- seed  in  WIDTH  lane i is loaded with seed + i (mod 2^WIDTH) at accepted start.
- abort  in  1  cancels a run in progress.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse on completion.
- checksum  out  WIDTH  XOR of all lanes, registered when done pulses.
- rd_idx  in  $clog2(LANES)  lane select for the read port.
- rd_data  out  WIDTH  registered copy of lane rd_idx.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; all lanes, round counter, latched mode, busy, done, checksum and rd_data = 0.
- States:
  - IDLE: busy=0. If start=1: latch mode and rounds, load lane i = seed+i, go to LOAD.
  - LOAD: one cycle. If the latched rounds = 0, go to DONE. Otherwise load counter = rounds and go to RUN.
  - RUN: each cycle apply one round and decrement the counter. On the cycle the counter goes 1 to 0, go to DONE. If abort=1, go to IDLE without applying a round and without pulsing done; lanes keep their values.
  - DONE: done=1 for exactly this cycle; checksum = XOR of all lanes; next state is IDLE.
- Latency: start accepted at edge T; with rounds=N≥1, done is high in the cycle after edge T+N+1. With rounds=0, done is high after edge T+1 and the lanes hold the seed values.
- start is ignored outside IDLE. start=1 in the DONE cycle is not accepted; it is accepted on the next cycle if still high.
- abort is ignored outside RUN. abort in the same cycle as the final round wins: no update, no done.
- Mode 0 round: sequential in-place chain for i = 0..LANES-1, with indices mod LANES and each step seeing values already updated earlier in the same round:
  - s[i] = s[i] + s[i-1] - s[i-2]
- Mode 1 round: sequential in-place chain for i = 0..LANES-1, indices mod LANES, same in-order semantics:
  - s[i] = s[i] ^ ((s[i+3] << SHIFT) truncated to WIDTH)
- The full round is one combinational chain, committed in a single edge.
- Wrap-around: all add/subtract results wrap modulo 2^WIDTH; shifted-out bits are discarded.
- Read port: rd_data <= lane[rd_idx] every cycle in every state (1-cycle latency). It shows the values as of the previous edge, including mid-run values. rd_idx ≥ LANES returns 0.
- checksum holds its value until the next DONE or reset.
- Reset mid-RUN: all state is cleared immediately and no done pulse is produced.

Test Plan:
- Reset → busy=0, done=0, checksum=0; rd_data=0 for every rd_idx.
- seed=0, mode=0, rounds=1 → done 3 cycles after start. Lanes = [1, FFFFFFFB, FFFFFFFC, 4, 0C, 0D, 7, 1] (hex); checksum=5.
- seed=0, mode=1, rounds=1 → lanes = [30000, 40001, 50002, 60003, 70004, 5, 10006, 20007] (hex); checksum=0.
- seed=10, rounds=0 → done 2 cycles after start; lanes = 10..17; checksum=0; busy high exactly 1 cycle.
- rounds=100, abort asserted on the 5th RUN cycle → no done pulse, busy drops. Lanes equal a reference model after 4 rounds. A start held high during RUN is ignored.
- Reset asserted mid-run (rounds=50) → lanes, busy and done go to 0 asynchronously. A fresh run with seed=0, mode=0, rounds=1 reproduces the second scenario exactly.
